// File: rtl/instruction_memory_pingpong.sv
// -----------------------------------------------------------------------------
// instruction_memory_pingpong
//
// Double-buffered instruction store. The host loads one bank over an AXI4
// slave (INCR bursts, byte strobes, checked B response) while the decoder
// fetches from the other bank. A bank_swap pulse flips which bank the decoder
// sees. If a host write is in flight, the flip waits for that write to finish.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   s_read_req_b/addr_b      decoder fetch request and word address (active bank)
//   s_read_data_b/valid_b    fetched word (held), valid pulse one cycle after req
//   bank_swap, active_bank   swap pulse in, bank currently served to the decoder
//   pci_cl_data_aw*/w*/b*    AXI4 write address / data / response channels
//   pci_cl_data_ar*/r*       AXI4 read address / data channels
//
// Host byte address: [BYTE_ADDR_W-1:0] ignored, next ADDR_WIDTH bits are the
// word index, the bit above that selects the bank, higher bits are ignored.
// -----------------------------------------------------------------------------
module instruction_memory_pingpong #(
  parameter int DATA_WIDTH       = 32,
  parameter int SIZE_IN_BITS     = 1 << 16,
  parameter int ADDR_WIDTH       = $clog2(SIZE_IN_BITS / DATA_WIDTH),
  parameter int INST_DATA_WIDTH  = 32,
  parameter int INST_ADDR_WIDTH  = 32,
  parameter int INST_WSTRB_WIDTH = INST_DATA_WIDTH / 8,
  parameter int INST_BURST_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  // decoder port
  input  logic                        s_read_req_b,
  input  logic [ADDR_WIDTH-1:0]       s_read_addr_b,
  output logic [DATA_WIDTH-1:0]       s_read_data_b,
  output logic                        s_read_valid_b,
  // bank control
  input  logic                        bank_swap,
  output logic                        active_bank,
  // AXI4 write address
  input  logic [INST_ADDR_WIDTH-1:0]  pci_cl_data_awaddr,
  input  logic [INST_BURST_WIDTH-1:0] pci_cl_data_awlen,
  input  logic [2:0]                  pci_cl_data_awsize,
  input  logic [1:0]                  pci_cl_data_awburst,
  input  logic                        pci_cl_data_awvalid,
  output logic                        pci_cl_data_awready,
  // AXI4 write data
  input  logic [INST_DATA_WIDTH-1:0]  pci_cl_data_wdata,
  input  logic [INST_WSTRB_WIDTH-1:0] pci_cl_data_wstrb,
  input  logic                        pci_cl_data_wlast,
  input  logic                        pci_cl_data_wvalid,
  output logic                        pci_cl_data_wready,
  // AXI4 write response
  output logic [1:0]                  pci_cl_data_bresp,
  output logic                        pci_cl_data_bvalid,
  input  logic                        pci_cl_data_bready,
  // AXI4 read address
  input  logic [INST_ADDR_WIDTH-1:0]  pci_cl_data_araddr,
  input  logic [INST_BURST_WIDTH-1:0] pci_cl_data_arlen,
  input  logic [2:0]                  pci_cl_data_arsize,
  input  logic [1:0]                  pci_cl_data_arburst,
  input  logic                        pci_cl_data_arvalid,
  output logic                        pci_cl_data_arready,
  // AXI4 read data
  output logic [INST_DATA_WIDTH-1:0]  pci_cl_data_rdata,
  output logic [1:0]                  pci_cl_data_rresp,
  output logic                        pci_cl_data_rlast,
  output logic                        pci_cl_data_rvalid,
  input  logic                        pci_cl_data_rready
);

  localparam int BYTE_ADDR_W = $clog2(INST_WSTRB_WIDTH);
  localparam int BANK_BIT    = ADDR_WIDTH + BYTE_ADDR_W;
  localparam int DEPTH       = 2 ** (ADDR_WIDTH + 1);

  typedef enum logic [2:0] {
    H_IDLE,
    H_WDATA,
    H_WRESP,
    H_RREQ,
    H_RDATA
  } host_state_t;

  host_state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        bank_q, bank_d;
  logic [INST_BURST_WIDTH-1:0] len_q, len_d;
  logic [INST_BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                        err_q, err_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        active_bank_q, active_bank_d;
  logic                        swap_pending_q, swap_pending_d;
  logic [DATA_WIDTH-1:0]       s_read_data_q, s_read_data_d;
  logic                        s_read_valid_q, s_read_valid_d;

  // Both banks live in one array; the top index bit is the bank.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH:0]   mem_waddr;

  // Size/burst type are treated as INCR full-word, and the address bits
  // outside the word index/bank field are don't-care.
  logic unused_ok;
  assign unused_ok = ^{pci_cl_data_awsize, pci_cl_data_awburst,
                       pci_cl_data_arsize, pci_cl_data_arburst,
                       pci_cl_data_awaddr[BYTE_ADDR_W-1:0],
                       pci_cl_data_araddr[BYTE_ADDR_W-1:0],
                       pci_cl_data_awaddr[INST_ADDR_WIDTH-1:BANK_BIT+1],
                       pci_cl_data_araddr[INST_ADDR_WIDTH-1:BANK_BIT+1]};

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign mem_we    = (state_q == H_WDATA) && pci_cl_data_wvalid;
  assign mem_waddr = {bank_q, addr_q};

  // NOTE: the RAM array has no reset so it can map onto block RAM; contents
  // survive reset and only the control state is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < INST_WSTRB_WIDTH; i++) begin
        if (pci_cl_data_wstrb[i]) begin
          mem[mem_waddr][i*8 +: 8] <= pci_cl_data_wdata[i*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample pre-edge values; this is also what makes a same-cycle read of a
  // word being written return the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= H_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Host FSM: next state and burst datapath
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      H_IDLE: begin
        // Write wins a tie: arready is low whenever awvalid is high.
        if (pci_cl_data_awvalid) begin
          addr_d     = pci_cl_data_awaddr[BANK_BIT-1:BYTE_ADDR_W];
          bank_d     = pci_cl_data_awaddr[BANK_BIT];
          len_d      = pci_cl_data_awlen;
          beat_cnt_d = '0;
          state_d    = H_WDATA;
        end else if (pci_cl_data_arvalid) begin
          addr_d     = pci_cl_data_araddr[BANK_BIT-1:BYTE_ADDR_W];
          bank_d     = pci_cl_data_araddr[BANK_BIT];
          len_d      = pci_cl_data_arlen;
          beat_cnt_d = '0;
          state_d    = H_RREQ;
        end
      end
      H_WDATA: begin
        if (pci_cl_data_wvalid) begin
          // Word index wraps inside the bank; bank_q is never touched here.
          addr_d     = addr_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (pci_cl_data_wlast) begin
            err_d   = (beat_cnt_q != len_q);
            state_d = H_WRESP;
          end
        end
      end
      H_WRESP: begin
        if (pci_cl_data_bready) begin
          state_d = H_IDLE;
        end
      end
      H_RREQ: begin
        rdata_d = mem[{bank_q, addr_q}];
        state_d = H_RDATA;
      end
      H_RDATA: begin
        if (pci_cl_data_rready) begin
          if (beat_cnt_q == len_q) begin
            state_d = H_IDLE;
          end else begin
            addr_d     = addr_q + 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = H_RREQ;
          end
        end
      end
      default: state_d = H_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Host FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pci_cl_data_awready = (state_q == H_IDLE) && !reset;
    pci_cl_data_arready = (state_q == H_IDLE) && !pci_cl_data_awvalid && !reset;
    pci_cl_data_wready  = (state_q == H_WDATA);
    pci_cl_data_bvalid  = (state_q == H_WRESP);
    pci_cl_data_bresp   = err_q ? 2'b10 : 2'b00;
    pci_cl_data_rvalid  = (state_q == H_RDATA);
    pci_cl_data_rlast   = (state_q == H_RDATA) && (beat_cnt_q == len_q);
    pci_cl_data_rresp   = 2'b00;
    pci_cl_data_rdata   = rdata_q;
  end

  // ---------------------------------------------------------------------------
  // Bank swap: immediate outside a write, deferred to the end of the B
  // handshake during one. Any number of pulses while deferred give one toggle.
  // ---------------------------------------------------------------------------
  logic in_write;
  logic wresp_done;
  logic swap_req;

  always_comb begin
    in_write       = (state_q == H_WDATA) || (state_q == H_WRESP);
    wresp_done     = (state_q == H_WRESP) && pci_cl_data_bready;
    swap_req       = swap_pending_q || bank_swap;
    active_bank_d  = active_bank_q;
    swap_pending_d = swap_pending_q;
    if (in_write) begin
      if (wresp_done) begin
        swap_pending_d = 1'b0;
        if (swap_req) begin
          active_bank_d = ~active_bank_q;
        end
      end else begin
        swap_pending_d = swap_req;
      end
    end else if (bank_swap) begin
      active_bank_d = ~active_bank_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder port: read-only, always the active bank as seen before this edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_read_valid_d = s_read_req_b;
    s_read_data_d  = s_read_data_q;
    if (s_read_req_b) begin
      s_read_data_d = mem[{active_bank_q, s_read_addr_b}];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q         <= '0;
      bank_q         <= 1'b0;
      len_q          <= '0;
      beat_cnt_q     <= '0;
      err_q          <= 1'b0;
      rdata_q        <= '0;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      s_read_data_q  <= '0;
      s_read_valid_q <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      bank_q         <= bank_d;
      len_q          <= len_d;
      beat_cnt_q     <= beat_cnt_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      s_read_data_q  <= s_read_data_d;
      s_read_valid_q <= s_read_valid_d;
    end
  end

  assign active_bank    = active_bank_q;
  assign s_read_data_b  = s_read_data_q;
  assign s_read_valid_b = s_read_valid_q;

endmodule

// File: tb/tb_instruction_memory_pingpong.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory_pingpong
//
// Directed bench for instruction_memory_pingpong. Inputs are driven on the
// falling edge and outputs sampled on the falling edge (or just after it), so
// every sample sits half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_memory_pingpong;

  localparam int AW    = 11;
  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_read_req_b;
  logic [AW-1:0] s_read_addr_b;
  logic [31:0] s_read_data_b;
  logic        s_read_valid_b;
  logic        bank_swap;
  logic        active_bank;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  instruction_memory_pingpong dut (
    .clk                 (clk),
    .reset               (reset),
    .s_read_req_b        (s_read_req_b),
    .s_read_addr_b       (s_read_addr_b),
    .s_read_data_b       (s_read_data_b),
    .s_read_valid_b      (s_read_valid_b),
    .bank_swap           (bank_swap),
    .active_bank         (active_bank),
    .pci_cl_data_awaddr  (awaddr),
    .pci_cl_data_awlen   (awlen),
    .pci_cl_data_awsize  (awsize),
    .pci_cl_data_awburst (awburst),
    .pci_cl_data_awvalid (awvalid),
    .pci_cl_data_awready (awready),
    .pci_cl_data_wdata   (wdata),
    .pci_cl_data_wstrb   (wstrb),
    .pci_cl_data_wlast   (wlast),
    .pci_cl_data_wvalid  (wvalid),
    .pci_cl_data_wready  (wready),
    .pci_cl_data_bresp   (bresp),
    .pci_cl_data_bvalid  (bvalid),
    .pci_cl_data_bready  (bready),
    .pci_cl_data_araddr  (araddr),
    .pci_cl_data_arlen   (arlen),
    .pci_cl_data_arsize  (arsize),
    .pci_cl_data_arburst (arburst),
    .pci_cl_data_arvalid (arvalid),
    .pci_cl_data_arready (arready),
    .pci_cl_data_rdata   (rdata),
    .pci_cl_data_rresp   (rresp),
    .pci_cl_data_rlast   (rlast),
    .pci_cl_data_rvalid  (rvalid),
    .pci_cl_data_rready  (rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] resp;
  logic       act_at_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Host write burst: nbeats beats of data0, data0+1, ... with wlast on the
  // final beat; awlen is given separately so mismatches can be provoked.
  task automatic host_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                            input logic [31:0] data0, input logic [3:0] strb,
                            output logic [1:0] rsp);
    int n;
    @(negedge clk);
    awaddr = addr; awlen = len; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < LIMIT) begin @(negedge clk); #1; n++; end
    check("aw_handshake", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = data0 + 32'(i); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      #1;
      n = 0;
      while (!wready && n < LIMIT) begin @(negedge clk); #1; n++; end
      check("w_handshake", 32'(wready), 32'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    #1;
    n = 0;
    while (!bvalid && n < LIMIT) begin @(negedge clk); #1; n++; end
    check("b_valid", 32'(bvalid), 32'd1);
    rsp      = bresp;
    act_at_b = active_bank;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Decoder fetch: data and valid one cycle after the request, valid then drops.
  task automatic dec_read(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    s_read_req_b = 1'b1; s_read_addr_b = a;
    @(negedge clk);
    s_read_req_b = 1'b0;
    check({nm, "_data"}, s_read_data_b, exp);
    check({nm, "_valid"}, 32'(s_read_valid_b), 32'd1);
    @(negedge clk);
    check({nm, "_valid_pulse"}, 32'(s_read_valid_b), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } wr_vec_t;

  wr_vec_t     vecs [10];
  logic [31:0] exp_r [8];

  initial begin
    int          n, beats, cyc;
    logic        stalled;
    logic [31:0] held;
    logic [AW-1:0] word;

    // Single-beat writes to bank 0 (active) followed by a decoder readback.
    vecs[0] = '{32'h0000_0014, 32'h1122_3344, 4'hF, 32'h1122_3344};
    vecs[1] = '{32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD};
    vecs[2] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0010, 32'h0000_0000, 4'h8, 32'h00AD_BEEF};
    vecs[4] = '{32'h0000_0018, 32'h1234_5678, 4'hF, 32'h1234_5678};
    vecs[5] = '{32'h0000_0018, 32'hFFFF_FFFF, 4'h2, 32'h1234_FF78};
    vecs[6] = '{32'h0000_001C, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D};
    vecs[7] = '{32'h0000_001C, 32'h5555_5555, 4'h0, 32'hCAFE_F00D};
    vecs[8] = '{32'h0000_1FFC, 32'h0BAD_CAFE, 4'hF, 32'h0BAD_CAFE};
    vecs[9] = '{32'h0001_0003, 32'h0000_0010, 4'h1, 32'h0000_0010};

    reset = 1'b1;
    s_read_req_b = 1'b0; s_read_addr_b = '0; bank_swap = 1'b0;
    awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_active_bank", 32'(active_bank), 32'd0);
    check("rst_rd_valid", 32'(s_read_valid_b), 32'd0);
    check("rst_rd_data", s_read_data_b, 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_awready", 32'(awready), 32'd1);
    check("idle_arready", 32'(arready), 32'd1);

    // ---- 4-beat burst into bank 0, decoder reads it back ----
    host_write(32'h0, 8'd3, 4, 32'd1, 4'hF, resp);
    check("burst4_bresp", 32'(resp), 32'd0);
    for (int i = 0; i < 4; i++) begin
      word = AW'(i);
      dec_read(word, 32'(i + 1), "burst4_rd");
    end

    // ---- table: strobed single-beat writes ----
    for (int i = 0; i < 10; i++) begin
      host_write(vecs[i].addr, 8'd0, 1, vecs[i].data, vecs[i].strb, resp);
      check("tbl_bresp", 32'(resp), 32'd0);
      word = vecs[i].addr[12:2];
      dec_read(word, vecs[i].exp, "tbl_rd");
    end

    // ---- word index wraps inside the bank, bank bit held ----
    host_write(32'h0000_1FFC, 8'd1, 2, 32'hA0, 4'hF, resp);
    check("wrap_bresp", 32'(resp), 32'd0);
    dec_read(11'd2047, 32'hA0, "wrap_last");
    dec_read(11'd0, 32'hA1, "wrap_first");

    // ---- AXI read burst with stalls ----
    exp_r = '{32'hA1, 32'd2, 32'd3, 32'd4, 32'h00AD_BEEF, 32'h11BB_33DD,
              32'h1234_FF78, 32'hCAFE_F00D};
    @(negedge clk);
    araddr = 32'h0; arlen = 8'd7; arvalid = 1'b1;
    #1;
    check("ar_handshake", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    beats = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (beats < 8 && cyc < 200) begin
      rready = ($urandom_range(0, 2) != 0);
      #1;
      if (rvalid) begin
        if (stalled) check("r_stable", rdata, held);
        if (rready) begin
          check("r_data", rdata, exp_r[beats]);
          check("r_last", 32'(rlast), 32'(beats == 7));
          check("r_resp", 32'(rresp), 32'd0);
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    check("r_beat_count", 32'(beats), 32'd8);
    #1;
    check("r_done_rvalid", 32'(rvalid), 32'd0);

    // ---- fill bank 1 while the decoder streams bank 0, then swap ----
    fork
      host_write(32'h0000_2000, 8'd3, 4, 32'h100, 4'hF, resp);
      begin
        dec_read(11'd1, 32'd2, "stream_rd");
        dec_read(11'd2, 32'd3, "stream_rd");
        dec_read(11'd3, 32'd4, "stream_rd");
      end
    join
    check("bank1_bresp", 32'(resp), 32'd0);
    check("pre_swap_bank", 32'(active_bank), 32'd0);
    @(negedge clk);
    bank_swap = 1'b1; s_read_req_b = 1'b1; s_read_addr_b = 11'd1;
    @(negedge clk);
    bank_swap = 1'b0; s_read_req_b = 1'b0;
    check("swap_bank", 32'(active_bank), 32'd1);
    check("swap_cycle_old_bank", s_read_data_b, 32'd2);
    dec_read(11'd1, 32'h101, "bank1_rd");
    dec_read(11'd3, 32'h103, "bank1_rd");

    // ---- swap pulses during a 16-beat write are deferred and merged ----
    fork
      host_write(32'h0000_0040, 8'd15, 16, 32'h5000, 4'hF, resp);
      begin
        repeat (3) @(negedge clk);
        bank_swap = 1'b1;
        @(negedge clk);
        bank_swap = 1'b0;
        check("deferred_swap_1", 32'(active_bank), 32'd1);
        repeat (3) @(negedge clk);
        bank_swap = 1'b1;
        @(negedge clk);
        bank_swap = 1'b0;
        check("deferred_swap_2", 32'(active_bank), 32'd1);
      end
    join
    check("long_bresp", 32'(resp), 32'd0);
    check("bank_at_bvalid", 32'(act_at_b), 32'd1);
    check("bank_after_b", 32'(active_bank), 32'd0);
    repeat (2) @(negedge clk);
    check("bank_single_toggle", 32'(active_bank), 32'd0);
    dec_read(11'd16, 32'h5000, "long_rd");
    dec_read(11'd31, 32'h500F, "long_rd");

    // ---- collision: host write and decoder read of the same word ----
    fork
      host_write(32'h0000_0010, 8'd0, 1, 32'h7777_7777, 4'hF, resp);
      begin
        repeat (2) @(negedge clk);
        s_read_req_b = 1'b1; s_read_addr_b = 11'd4;
        @(negedge clk);
        s_read_req_b = 1'b0;
        check("collision_old_word", s_read_data_b, 32'h00AD_BEEF);
      end
    join
    dec_read(11'd4, 32'h7777_7777, "collision_new_word");

    // ---- early wlast gives SLVERR ----
    host_write(32'h0000_0080, 8'd3, 3, 32'h900, 4'hF, resp);
    check("early_wlast_bresp", 32'(resp), 32'd2);
    #1;
    check("err_back_idle", 32'(awready), 32'd1);
    check("err_next_okay_ok", 32'(bvalid), 32'd0);

    // ---- write wins an aw/ar tie ----
    @(negedge clk);
    awaddr = 32'h0; awvalid = 1'b1; arvalid = 1'b1;
    #1;
    check("tie_arready_low", 32'(arready), 32'd0);
    awvalid = 1'b0;
    #1;
    check("tie_arready_high", 32'(arready), 32'd1);
    arvalid = 1'b0;

    // ---- swap in idle, then reset in the middle of a read burst ----
    @(negedge clk);
    bank_swap = 1'b1;
    @(negedge clk);
    bank_swap = 1'b0;
    check("idle_swap", 32'(active_bank), 32'd1);
    araddr = 32'h0; arlen = 8'd7; arvalid = 1'b1;
    #1;
    check("mid_ar_handshake", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b0;
    #1;
    n = 0;
    while (!rvalid && n < LIMIT) begin @(negedge clk); #1; n++; end
    check("mid_rvalid_seen", 32'(rvalid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_bank", 32'(active_bank), 32'd0);
    check("mid_rst_rd_data", s_read_data_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_arready", 32'(arready), 32'd1);
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    repeat (3) @(negedge clk);
    check("post_rst_quiet_r", 32'(rvalid), 32'd0);
    check("post_rst_quiet_b", 32'(bvalid), 32'd0);
    dec_read(11'd5, 32'h11BB_33DD, "post_rst_ram_kept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
